// File: rtl/seg_display_sequencer.sv
// seg_display_sequencer
//   Converts a captured W-bit operand (signed-magnitude or two's complement)
//   into a sign glyph plus three 7-segment digits using a one-bit-per-cycle
//   shift-add-3 (double-dabble) engine. All display outputs change together
//   on the final edge of a conversion, which also raises a one-cycle Done.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   synchronous, active-high reset (blanks the display)
//   Start     in   conversion request, honoured only while idle
//   N         in   W-bit operand, captured on the accepting edge
//   Encoding  in   0 = signed-magnitude, 1 = two's complement
//   Busy      out  conversion in progress
//   Done      out  one-cycle pulse after the display outputs update
//   Sign      out  active-low sign segments (minus or blank)
//   D2/D1/D0  out  active-low hundreds/tens/units segments
//   TooLarge  out  displayed value is the overflow dash pattern
module seg_display_sequencer #(
    parameter int W = 11
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] N,
    input  logic         Encoding,
    output logic         Busy,
    output logic         Done,
    output logic [6:0]   Sign,
    output logic [6:0]   D2,
    output logic [6:0]   D1,
    output logic [6:0]   D0,
    output logic         TooLarge
);

    localparam int CW = $clog2(W + 1);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'd64;
            4'd1:    g = 7'd121;
            4'd2:    g = 7'd36;
            4'd3:    g = 7'd48;
            4'd4:    g = 7'd25;
            4'd5:    g = 7'd18;
            4'd6:    g = 7'd2;
            4'd7:    g = 7'd120;
            4'd8:    g = 7'd0;
            4'd9:    g = 7'd16;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

    state_t          state_q,  state_d;
    logic [W-1:0]    mag_q,    mag_d;
    logic [11:0]     bcd_q,    bcd_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            neg_q,    neg_d;      // captured sign bit
    logic            ovf_q,    ovf_d;      // captured magnitude > 999
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic [6:0]      sign_q,   sign_d;
    logic [6:0]      d2_q,     d2_d;
    logic [6:0]      d1_q,     d1_d;
    logic [6:0]      d0_q,     d0_d;
    logic            tl_q,     tl_d;

    logic [W-1:0]    cap_mag;
    logic [W-1:0]    neg_n;
    logic [11:0]     bcd_adj;

    // Magnitude of the incoming operand. In two's complement the most
    // negative value negates to itself, which read unsigned is 2^(W-1).
    always_comb begin
        neg_n = ~N + {{(W-1){1'b0}}, 1'b1};
        if (Encoding)
            cap_mag = N[W-1] ? neg_n : N;
        else
            cap_mag = {1'b0, N[W-2:0]};
    end

    // Add-3 correction for each BCD nibble before it is doubled.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        tl_d    = tl_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    neg_d   = N[W-1];
                    mag_d   = cap_mag;
                    ovf_d   = (cap_mag > W'(999));
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // Bits shifted out of the top of the BCD register are
                // dropped; they only occur for values the dash display hides.
                bcd_d = {bcd_adj[10:0], mag_q[W-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1))
                    state_d = UPDATE;
            end

            UPDATE: begin
                if (ovf_q) begin
                    sign_d = SEG_MINUS;
                    d2_d   = SEG_MINUS;
                    d1_d   = SEG_MINUS;
                    d0_d   = SEG_MINUS;
                    tl_d   = 1'b1;
                end else begin
                    tl_d   = 1'b0;
                    sign_d = neg_q ? SEG_MINUS : SEG_OFF;
                    // Leading-zero blanking; units always shows a digit.
                    d2_d   = (bcd_q[11:8] == 4'd0) ? SEG_OFF : glyph(bcd_q[11:8]);
                    d1_d   = (bcd_q[11:4] == 8'd0) ? SEG_OFF : glyph(bcd_q[7:4]);
                    d0_d   = glyph(bcd_q[3:0]);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= SEG_OFF;
            d2_q    <= SEG_OFF;
            d1_q    <= SEG_OFF;
            d0_q    <= SEG_OFF;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            tl_q    <= tl_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Sign     = sign_q;
    assign D2       = d2_q;
    assign D1       = d1_q;
    assign D0       = d0_q;
    assign TooLarge = tl_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Scoreboard bench for seg_display_sequencer: each accepted request pushes
// its expected display and due cycle; Done pops and compares.
module tb_seg_display_sequencer;

    localparam int W   = 11;
    localparam int LAT = W + 1;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] N = '0;
    logic         Encoding = 1'b0;
    logic         Busy, Done, TooLarge;
    logic [6:0]   Sign, D2, D1, D0;

    seg_display_sequencer #(.W(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .N(N), .Encoding(Encoding),
        .Busy(Busy), .Done(Done), .Sign(Sign), .D2(D2), .D1(D1), .D0(D0),
        .TooLarge(TooLarge)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         due;
        logic [6:0] sign, d2, d1, d0;
        logic       tl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rem     = 0;   // edges until the model returns to idle

    int glyph_tab[10] = '{64, 121, 36, 48, 25, 18, 2, 120, 0, 16};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] n, input logic enc);
        exp_t e;
        int   mag, h, t, u;
        logic neg;
        neg = n[W-1];
        if (enc) mag = neg ? ((1 << W) - int'(n)) : int'(n);
        else     mag = int'(n) & ((1 << (W-1)) - 1);
        e.due = 0;
        if (mag > 999) begin
            e.sign = 7'd63; e.d2 = 7'd63; e.d1 = 7'd63; e.d0 = 7'd63; e.tl = 1'b1;
        end else begin
            h = mag / 100; t = (mag / 10) % 10; u = mag % 10;
            e.tl   = 1'b0;
            e.sign = neg ? 7'd63 : 7'd127;
            e.d2   = (h == 0) ? 7'd127 : 7'(glyph_tab[h]);
            e.d1   = (h == 0 && t == 0) ? 7'd127 : 7'(glyph_tab[t]);
            e.d0   = 7'(glyph_tab[u]);
        end
        return e;
    endfunction

    // One clock: drive, clock, advance the acceptance model, then check.
    task automatic step(input logic st, input logic [W-1:0] n, input logic enc, input logic rst);
        exp_t e;
        Start = st; N = n; Encoding = enc; Reset = rst;
        @(posedge Clock);
        cyc++;
        if (rst) begin
            rem = 0;
            q.delete();
        end else if (rem == 0 && st) begin
            e = model(n, enc);
            e.due = cyc + LAT;
            q.push_back(e);
            rem = LAT;
        end else if (rem > 0) begin
            rem--;
        end
        #1;
        chk("busy", 32'(Busy), 32'(rem != 0));
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("done", 32'(Done), 32'd1);
            chk("sign", 32'(Sign), 32'(e.sign));
            chk("d2",   32'(D2),   32'(e.d2));
            chk("d1",   32'(D1),   32'(e.d1));
            chk("d0",   32'(D0),   32'(e.d0));
            chk("too_large", 32'(TooLarge), 32'(e.tl));
        end else begin
            chk("done_idle", 32'(Done), 32'd0);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 40) begin
            step(1'b0, '0, 1'b0, 1'b0);
            guard++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic conv(input logic [W-1:0] n, input logic enc);
        step(1'b1, n, enc, 1'b0);
        drain();
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_sign"}, 32'(Sign), 32'd127);
        chk({tag, "_d2"},   32'(D2),   32'd127);
        chk({tag, "_d1"},   32'(D1),   32'd127);
        chk({tag, "_d0"},   32'(D0),   32'd127);
        chk({tag, "_tl"},   32'(TooLarge), 32'd0);
    endtask

    initial begin
        // Reset with Start held high: nothing may start.
        step(1'b1, 11'd5, 1'b0, 1'b1);
        step(1'b1, 11'd5, 1'b0, 1'b1);
        chk_blank("reset");
        chk("reset_done", 32'(Done), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        conv(11'd5, 1'b0);
        conv(11'h785, 1'b1);
        conv(11'd105, 1'b1);
        conv({1'b1, 10'd999}, 1'b0);
        conv(11'd1000, 1'b1);
        conv(11'h400, 1'b1);
        conv(11'h400, 1'b0);   // signed-magnitude negative zero

        // Start held high, operand churning every cycle.
        for (int i = 0; i < 45; i++)
            step(1'b1, W'($urandom), 1'($urandom), 1'b0);
        drain();

        // Reset at the fifth edge after acceptance aborts the conversion.
        step(1'b1, 11'd42, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk_blank("mid_reset");
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b0, 1'b0);
        conv(11'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
